// File: rtl/demux2_reg.sv
// Registered 1:2 demux: in_sel steers each beat to out0 or out1; 1-cycle latency, one beat/cycle per output.
// Backpressure: in_ready is combinational and blocks only while the selected output is full and stalled.
// Optional transfer counters enabled by `define DEMUX2_REG_CNT_EN (cnt0/cnt1 tie to 0 otherwise).
module demux2_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    output logic             out1_valid,
    input  logic             out0_ready,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
);

    logic             vld0_q, vld0_d, vld1_q, vld1_d;
    logic [WIDTH-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
    logic             in_xfer, ld0, ld1, out0_xfer, out1_xfer;

    assign in_ready  = in_sel ? (!vld1_q | out1_ready) : (!vld0_q | out0_ready);
    assign in_xfer   = in_valid & in_ready;
    assign ld0       = in_xfer & !in_sel;
    assign ld1       = in_xfer &  in_sel;
    assign out0_xfer = vld0_q & out0_ready;
    assign out1_xfer = vld1_q & out1_ready;

    // A load wins over a drain so a simultaneous pop/push keeps the stage full.
    always_comb begin
        vld0_d = vld0_q;
        dat0_d = dat0_q;
        vld1_d = vld1_q;
        dat1_d = dat1_q;
        if (ld0) begin
            vld0_d = 1'b1;
            dat0_d = in_data;
        end else if (out0_xfer) begin
            vld0_d = 1'b0;
        end
        if (ld1) begin
            vld1_d = 1'b1;
            dat1_d = in_data;
        end else if (out1_xfer) begin
            vld1_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld0_q <= 1'b0;
            vld1_q <= 1'b0;
            dat0_q <= '0;
            dat1_q <= '0;
        end else begin
            vld0_q <= vld0_d;
            vld1_q <= vld1_d;
            dat0_q <= dat0_d;
            dat1_q <= dat1_d;
        end
    end

    assign out0_valid = vld0_q;
    assign out1_valid = vld1_q;
    assign out0_data  = dat0_q;
    assign out1_data  = dat1_q;

`ifdef DEMUX2_REG_CNT_EN
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (out0_xfer && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
        if (out1_xfer && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = 16'd0;
    assign cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_demux2_reg.sv
// Directed + randomized bench for demux2_reg against a per-output queue reference model.
module tb_demux2_reg;

    localparam int WIDTH = 8;

`ifdef DEMUX2_REG_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             out0_valid, out1_valid;
    logic             out0_ready, out1_ready;
    logic [WIDTH-1:0] out0_data, out1_data;
    logic [15:0]      cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    // Reference model: beats waiting at each output, in acceptance order.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int               n0, n1;

    demux2_reg #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out1_valid (out1_valid),
        .out0_ready (out0_ready),
        .out1_ready (out1_ready),
        .out0_data  (out0_data),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt(input int n);
        if (!CNT_EN) return 16'd0;
        return (n > 65535) ? 16'hFFFF : n[15:0];
    endfunction

    // One clock: inputs already driven; check at negedge against the model, then advance it.
    task automatic step();
        logic exp_rdy;
        @(negedge clk);
        exp_rdy = in_sel ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
        chk("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
        if (q0.size() != 0) chk("out0_data", {24'd0, out0_data}, {24'd0, q0[0]});
        if (q1.size() != 0) chk("out1_data", {24'd0, out1_data}, {24'd0, q1[0]});
        chk("cnt0", {16'd0, cnt0}, {16'd0, exp_cnt(n0)});
        chk("cnt1", {16'd0, cnt1}, {16'd0, exp_cnt(n1)});
        if (q0.size() != 0 && out0_ready) begin void'(q0.pop_front()); n0++; end
        if (q1.size() != 0 && out1_ready) begin void'(q1.pop_front()); n1++; end
        if (in_valid && exp_rdy) begin
            if (in_sel) q1.push_back(in_data);
            else        q0.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                         input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        n0 = 0;
        n1 = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        model_reset();
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_v0", {31'd0, out0_valid}, 32'd0);
        chk("rst_v1", {31'd0, out1_valid}, 32'd0);
        chk("rst_d0", {24'd0, out0_data}, 32'd0);
        chk("rst_d1", {24'd0, out1_data}, 32'd0);
        chk("rst_cnt0", {16'd0, cnt0}, 32'd0);
        chk("rst_cnt1", {16'd0, cnt1}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single beat into stalled out0, then a second sel=0 beat must be refused.
        drive(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        step();
        chk("a5_v0", {31'd0, out0_valid}, 32'd1);
        chk("a5_d0", {24'd0, out0_data}, 32'hA5);
        chk("a5_v1", {31'd0, out1_valid}, 32'd0);
        drive(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        #1;
        chk("a5_blocked", {31'd0, in_ready}, 32'd0);
        step();

        // Drain, then 4 back-to-back beats to out1.
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b1, k[7:0], 1'b1, 1'b1);
            #1;
            chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
            if (k > 1) chk("b2b_d1", {24'd0, out1_data}, k - 1);
            step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("b2b_last", {24'd0, out1_data}, 32'h04);
        step();

        // Stalled out1 holding 33 must not block a sel=0 beat.
        drive(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
        #1;
        chk("iso_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("iso_d0", {24'd0, out0_data}, 32'h44);
        chk("iso_d1", {24'd0, out1_data}, 32'h33);
        chk("iso_v1", {31'd0, out1_valid}, 32'd1);
        step();

        // Asynchronous reset with both outputs full.
        rst_n = 1'b0;
        #1;
        chk("arst_v0", {31'd0, out0_valid}, 32'd0);
        chk("arst_v1", {31'd0, out1_valid}, 32'd0);
        chk("arst_d0", {24'd0, out0_data}, 32'd0);
        chk("arst_d1", {24'd0, out1_data}, 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;

        // 3 transfers on out0, 5 on out1.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, (k >= 3), 8'h10 + k[7:0], 1'b1, 1'b1);
            step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step();
        step();
        chk("cnt0_3", {16'd0, cnt0}, CNT_EN ? 32'd3 : 32'd0);
        chk("cnt1_5", {16'd0, cnt1}, CNT_EN ? 32'd5 : 32'd0);

        // Randomized traffic.
        for (int k = 0; k < 1000; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
            step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step();
        step();
        chk("drain_q0", q0.size(), 32'd0);
        chk("drain_q1", q1.size(), 32'd0);
        chk("drain_v0", {31'd0, out0_valid}, 32'd0);
        chk("drain_v1", {31'd0, out1_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
